// File: rtl/cla_nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// cla_nibble_serial_adder
//
// Purpose:
//   WIDTH-bit adder that reuses one 4-bit carry-lookahead adder over NIBBLES
//   clock cycles, least-significant nibble first. The carry between nibbles
//   is kept in a register. A start/done handshake frames each operation.
//   This trades latency for area in wide datapaths.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous reset, active-high
//   start  in   1      operation request, honoured only while ready=1
//   a      in   WIDTH  operand A, captured on an accepted start
//   b      in   WIDTH  operand B, captured on an accepted start
//   cin    in   1      carry-in, captured on an accepted start
//   ready  out  1      high in IDLE
//   busy   out  1      high in RUN
//   done   out  1      one-cycle pulse, sum/cout/ovf valid
//   sum    out  WIDTH  registered result, held until the next accepted start
//   cout   out  1      carry out of the most significant nibble
//   ovf    out  1      two's-complement overflow of the addition
//
// Timing: start accepted at edge 0, nibble passes on edges 1..NIBBLES, results
// and the done pulse registered on edge NIBBLES+1.
// ---------------------------------------------------------------------------

// Combinational 4-bit carry-lookahead adder.
module four_bit_cla_adder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);
   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = a & b;
   assign p = a ^ b;

   // All carries are flattened from generate/propagate terms so no carry
   // depends on a previously computed carry.
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_sum
         assign s[gi] = p[gi] ^ c[gi];
      end
   endgenerate

   assign cout = c[4];
endmodule

module cla_nibble_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int NIBBLES = WIDTH / 4;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_sh_q, a_sh_d;
   logic [WIDTH-1:0]   b_sh_q, b_sh_d;
   logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
   logic               carry_q, carry_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               a_msb_q, a_msb_d;
   logic               b_msb_q, b_msb_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;
   logic               done_q, done_d;

   logic [3:0]         nib_sum;
   logic               nib_cout;

   four_bit_cla_adder u_cla (
      .a    (a_sh_q[3:0]),
      .b    (b_sh_q[3:0]),
      .cin  (carry_q),
      .s    (nib_sum),
      .cout (nib_cout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         carry_q  <= 1'b0;
         idx_q    <= '0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         sum_sh_q <= sum_sh_d;
         carry_q  <= carry_d;
         idx_q    <= idx_d;
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         sum_q    <= sum_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      sum_sh_d = sum_sh_q;
      carry_d  = carry_q;
      idx_d    = idx_q;
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      sum_d    = sum_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      done_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_sh_d   = a;
               b_sh_d   = b;
               sum_sh_d = '0;
               carry_d  = cin;
               idx_d    = '0;
               // Sign bits are kept aside because the shift registers lose
               // them long before the overflow decision is made.
               a_msb_d  = a[WIDTH-1];
               b_msb_d  = b[WIDTH-1];
               sum_d    = '0;
               state_d  = S_RUN;
            end
         end

         S_RUN: begin
            a_sh_d   = {4'b0000, a_sh_q[WIDTH-1:4]};
            b_sh_d   = {4'b0000, b_sh_q[WIDTH-1:4]};
            // New nibble enters at the top; after NIBBLES passes the first
            // (least significant) nibble has arrived at bits [3:0].
            sum_sh_d = {nib_sum, sum_sh_q[WIDTH-1:4]};
            carry_d  = nib_cout;
            idx_d    = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            sum_d   = sum_sh_q;
            cout_d  = carry_q;
            ovf_d   = (a_msb_q == b_msb_q) && (sum_sh_q[WIDTH-1] != a_msb_q);
            done_d  = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign ready = (state_q == S_IDLE);
   assign busy  = (state_q == S_RUN);
   assign done  = done_q;
   assign sum   = sum_q;
   assign cout  = cout_q;
   assign ovf   = ovf_q;
endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
module tb_cla_nibble_serial_adder;
   localparam int W = 16;
   localparam int EXP_LAT = 5;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int done_cnt  = 0;
   int completed = 0;

   cla_nibble_serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
   end

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Drives one operation from IDLE and checks latency, result and pulse width.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                         input logic [W-1:0] es, input logic ec, input logic eo,
                         input string tag, input bit verbose);
      int lat;
      a = ta; b = tb_v; cin = tc; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, "_busy"}, 32'(busy), 32'd1);
      lat = 0;
      for (int e = 1; e <= 12; e++) begin
         @(posedge clk); #1;
         if (done) begin lat = e; break; end
      end
      check({tag, "_latency"}, lat, EXP_LAT);
      if (lat != 0) begin
         check({tag, "_result"}, {14'd0, ovf, cout, sum}, {14'd0, eo, ec, es});
         if (verbose)
            $display("op %s: %h + %h + %0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
                     tag, ta, tb_v, tc, sum, cout, ovf, lat);
         @(posedge clk); #1;
         check({tag, "_pulse"}, 32'(done), 32'd0);
         check({tag, "_ready"}, 32'(ready), 32'd1);
      end
      completed++;
   endtask

   initial begin
      int lat;
      int snap;
      logic [W-1:0] ra, rb;
      logic         rc;
      logic [W:0]   ref_v;
      logic         eovf;

      vecs[0] = '{16'h0007, 16'h0007, 1'b0, 16'h000E, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[4] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
      vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
      vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vecs[7] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
      vecs[8] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};

      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_state", {26'd0, ready, busy, done, cout, ovf, 1'b0}, {26'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      check("reset_sum", 32'(sum), 32'd0);
      $display("reset: ready=%0d busy=%0d done=%0d sum=%h", ready, busy, done, sum);

      for (int i = 0; i < 9; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].ovf,
                $sformatf("vec%0d", i), 1'b1);

      // start held high through RUN and DONE with different operands: ignored
      a = 16'h1234; b = 16'h4321; cin = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0;
      lat = 0;
      for (int e = 1; e <= 12; e++) begin
         @(posedge clk); #1;
         if (done) begin lat = e; break; end
      end
      start = 1'b0;
      check("ign_latency", lat, EXP_LAT);
      check("ign_result", {15'd0, cout, sum}, {15'd0, 1'b0, 16'h5556});
      $display("ignored-start op: sum=%h cout=%0d lat=%0d", sum, cout, lat);
      completed++;
      @(posedge clk); #1;
      check("ign_not_accepted", {30'd0, ready, busy}, {30'd0, 1'b1, 1'b0});

      // reset during the second RUN cycle discards the operation
      snap = done_cnt;
      a = 16'hFFFF; b = 16'h0001; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_mid_state", {28'd0, ready, busy, done, cout}, {28'd0, 1'b1, 1'b0, 1'b0, 1'b0});
      check("rst_mid_sum", {15'd0, ovf, sum}, 32'd0);
      repeat (8) @(posedge clk);
      #1;
      check("rst_mid_no_done", done_cnt - snap, 0);
      $display("mid-run reset: ready=%0d sum=%h done pulses=%0d", ready, sum, done_cnt - snap);
      run_op(16'h0007, 16'h0007, 1'b0, 16'h000E, 1'b0, 1'b0, "after_rst", 1'b1);

      // reset and start together: reset wins
      rst = 1'b1; start = 1'b1; a = 16'h0101; b = 16'h0101; cin = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      @(posedge clk); #1;
      check("rst_start_idle", {30'd0, ready, busy}, {30'd0, 1'b1, 1'b0});
      $display("rst+start: ready=%0d busy=%0d", ready, busy);

      for (int i = 0; i < 500; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom_range(0, 1));
         ref_v = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
         eovf = (ra[W-1] == rb[W-1]) && (ref_v[W-1] != ra[W-1]);
         run_op(ra, rb, rc, ref_v[W-1:0], ref_v[W], eovf, $sformatf("rnd%0d", i), 1'b1);
      end

      @(posedge clk); #1;
      check("done_count", done_cnt, completed);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
